// File: rtl/adc_sar_multi.sv
// Multi-channel bit-serial SAR ADC model streaming results over valid/ready.
// Optional per-channel offset calibration is enabled by defining ADC_OFFSET_CAL_EN.

module adc_sar_multi #(
  parameter int NUM_CH        = 4,
  parameter int ADC_BITS      = 12,
  parameter int IN_W          = 16,
  parameter int V_REF_MV      = 2500,
  parameter int SAMPLE_CYCLES = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*IN_W-1:0]     analog_in_mv,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic                       start,
  output logic                       busy,
  output logic signed [ADC_BITS-1:0] out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       frame_done
`ifdef ADC_OFFSET_CAL_EN
  ,
  input  logic                       cal_wr,
  input  logic [CH_W-1:0]            cal_ch,
  input  logic [ADC_BITS-1:0]        cal_offset
`endif
);

  localparam int CW   = IN_W + ADC_BITS + 2;
  localparam int BI_W = $clog2(ADC_BITS);
  localparam int SC_W = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [ADC_BITS-1:0] HALF_U = {1'b1, {(ADC_BITS-1){1'b0}}};
  localparam logic signed [ADC_BITS-1:0] CODE_MAX = {1'b0, {(ADC_BITS-1){1'b1}}};
  localparam logic signed [ADC_BITS-1:0] CODE_MIN = {1'b1, {(ADC_BITS-1){1'b0}}};
  localparam logic signed [CW-1:0] VREF_X = CW'(V_REF_MV);

  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, CONVERT = 2'd2, RESULT = 2'd3} state_t;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  state_t                     state_r, state_nxt_s;
  logic [NUM_CH-1:0]          mask_r, sel_oh_s, mask_rem_s;
  logic [CH_W-1:0]            sel_r;
  logic [SC_W-1:0]            scnt_r;
  logic [BI_W-1:0]            bit_r;
  logic [ADC_BITS-1:0]        sar_r, trial_s;
  logic signed [IN_W-1:0]     v_r, ch_in_s;
  logic signed [CW-1:0]       vx_s, diff_s, lhs_s, rhs_s;
  logic signed [ADC_BITS-1:0] code_s, code_out_s;
  logic                       start_ok_s, smp_done_s, conv_done_s, out_free_s, keep_s;
  logic                       sat_s, sat_out_s;
  logic                       accept_s, capture_s, step_s, load_s, last_s;

  assign start_ok_s  = start && (ch_enable != {NUM_CH{1'b0}});
  assign smp_done_s  = (scnt_r == SC_W'(SAMPLE_CYCLES));
  assign conv_done_s = (bit_r == {BI_W{1'b0}});
  assign out_free_s  = !out_valid || out_ready;
  assign mask_rem_s  = mask_r & ~sel_oh_s;

  always_comb begin
    sel_oh_s = {NUM_CH{1'b0}};
    ch_in_s  = {IN_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh_s[i] = (sel_r == CH_W'(i));
      ch_in_s = sel_oh_s[i] ? $signed(analog_in_mv[i*IN_W +: IN_W]) : ch_in_s;
    end
  end

  // Trial compare is done exactly in CW bits: (u_trial - half)*Vref <= v*half.
  assign trial_s = sar_r | ({{(ADC_BITS-1){1'b0}}, 1'b1} << bit_r);
  assign vx_s    = CW'(v_r);
  assign diff_s  = $signed(CW'(trial_s)) - $signed(CW'(HALF_U));
  assign lhs_s   = diff_s * VREF_X;
  assign rhs_s   = vx_s <<< (ADC_BITS - 1);
  assign keep_s  = (lhs_s <= rhs_s);
  assign code_s  = $signed({~sar_r[ADC_BITS-1], sar_r[ADC_BITS-2:0]});
  assign sat_s   = (vx_s >= VREF_X) || (vx_s < -VREF_X);

`ifdef ADC_OFFSET_CAL_EN
  logic signed [ADC_BITS-1:0] off_r [NUM_CH];
  logic signed [ADC_BITS:0]   wide_s;
  logic                       clamp_s;
  localparam logic signed [ADC_BITS:0] W_MAX = {2'b00, {(ADC_BITS-1){1'b1}}};
  localparam logic signed [ADC_BITS:0] W_MIN = {2'b11, {(ADC_BITS-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) off_r[i] <= {ADC_BITS{1'b0}};
    end else if (cal_wr) begin
      off_r[cal_ch] <= $signed(cal_offset);
    end
  end

  always_comb begin
    wide_s = $signed({code_s[ADC_BITS-1], code_s}) - $signed({off_r[sel_r][ADC_BITS-1], off_r[sel_r]});
    if (wide_s > W_MAX) begin
      code_out_s = CODE_MAX;
      clamp_s    = 1'b1;
    end else if (wide_s < W_MIN) begin
      code_out_s = CODE_MIN;
      clamp_s    = 1'b1;
    end else begin
      code_out_s = wide_s[ADC_BITS-1:0];
      clamp_s    = 1'b0;
    end
    sat_out_s = sat_s || clamp_s;
  end
`else
  assign code_out_s = code_s;
  assign sat_out_s  = sat_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start_ok_s ? SAMPLE : IDLE;
      SAMPLE:  state_nxt_s = smp_done_s ? CONVERT : SAMPLE;
      CONVERT: state_nxt_s = conv_done_s ? RESULT : CONVERT;
      RESULT: begin
        if (!out_free_s)                         state_nxt_s = RESULT;
        else if (mask_rem_s != {NUM_CH{1'b0}})   state_nxt_s = SAMPLE;
        else                                     state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  always_comb begin
    accept_s  = 1'b0;
    capture_s = 1'b0;
    step_s    = 1'b0;
    load_s    = 1'b0;
    last_s    = 1'b0;
    case (state_r)
      IDLE:    accept_s  = start_ok_s;
      SAMPLE:  capture_s = smp_done_s;
      CONVERT: step_s    = 1'b1;
      RESULT: begin
        load_s = out_free_s;
        last_s = out_free_s && (mask_rem_s == {NUM_CH{1'b0}});
      end
      default: accept_s = 1'b0;
    endcase
  end

  // The first channel of a frame starts its sample count at 0, later channels
  // at 1, so the start handshake buys one extra settling cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r <= {NUM_CH{1'b0}};
      sel_r  <= {CH_W{1'b0}};
      scnt_r <= {SC_W{1'b0}};
      bit_r  <= {BI_W{1'b0}};
      sar_r  <= {ADC_BITS{1'b0}};
      v_r    <= {IN_W{1'b0}};
    end else if (accept_s) begin
      mask_r <= ch_enable;
      sel_r  <= lowest_set(ch_enable);
      scnt_r <= SC_W'(0);
    end else if (load_s) begin
      mask_r <= mask_rem_s;
      sel_r  <= lowest_set(mask_rem_s);
      scnt_r <= SC_W'(1);
    end else if (capture_s) begin
      v_r   <= ch_in_s;
      sar_r <= {ADC_BITS{1'b0}};
      bit_r <= BI_W'(ADC_BITS - 1);
    end else if (state_r == SAMPLE) begin
      scnt_r <= scnt_r + SC_W'(1);
    end else if (step_s) begin
      sar_r <= keep_s ? trial_s : sar_r;
      bit_r <= bit_r - BI_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= {ADC_BITS{1'b0}};
      out_ch     <= {CH_W{1'b0}};
      out_sat    <= 1'b0;
    end else begin
      busy       <= (state_nxt_s != IDLE);
      frame_done <= last_s;
      if (load_s) begin
        out_valid <= 1'b1;
        out_data  <= code_out_s;
        out_ch    <= sel_r;
        out_sat   <= sat_out_s;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sar_multi.sv
// Directed bench for adc_sar_multi: boundary vector table plus multi-cycle
// sequences for multi-channel frames, backpressure, ignored starts and reset.

module tb_adc_sar_multi;
  localparam int NUM_CH = 4, ADC_BITS = 12, IN_W = 16, CH_W = 2;

  logic                   clk, rst_n, start, busy, out_sat, out_valid, out_ready, frame_done;
  logic [NUM_CH*IN_W-1:0] analog_in_mv;
  logic [NUM_CH-1:0]      ch_enable;
  logic [ADC_BITS-1:0]    out_data;
  logic [CH_W-1:0]        out_ch;
`ifdef ADC_OFFSET_CAL_EN
  logic                   cal_wr;
  logic [CH_W-1:0]        cal_ch;
  logic [ADC_BITS-1:0]    cal_offset;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  adc_sar_multi #(.NUM_CH(NUM_CH), .ADC_BITS(ADC_BITS), .IN_W(IN_W),
                  .V_REF_MV(2500), .SAMPLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .analog_in_mv(analog_in_mv), .ch_enable(ch_enable),
    .start(start), .busy(busy), .out_data(out_data), .out_ch(out_ch),
    .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done)
`ifdef ADC_OFFSET_CAL_EN
    , .cal_wr(cal_wr), .cal_ch(cal_ch), .cal_offset(cal_offset)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic signed [15:0] vin;
    int                 exp_code;
    logic               exp_sat;
  } vec_t;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int ch, input int mv);
    analog_in_mv[ch*IN_W +: IN_W] = IN_W'(mv);
  endtask

  // Start is seen on the next edge (edge 0); ch_enable is cleared afterwards.
  task automatic kick(input logic [NUM_CH-1:0] m);
    start = 1'b1;
    ch_enable = m;
    step(1);
    start = 1'b0;
    ch_enable = 4'b0000;
  endtask

  task automatic wait_valid(input string name, input int bound, output int edges);
    edges = 0;
    do begin
      step(1);
      edges++;
    end while (edges < bound && out_valid !== 1'b1);
    check({name, "_valid_seen"}, out_valid, 1);
  endtask

  vec_t vecs[14];
  int   e, nres, fds, bad;
  logic held_ok;
  int   got_ch[8], got_code[8], got_sat[8];
  int   exp_ch[4]   = '{0, 1, 2, 3};
  int   exp_code[4] = '{81, -164, 2047, -2048};
  int   exp_sat[4]  = '{0, 0, 1, 1};

  initial begin
    vecs[0]  = '{16'sd1000,   819,  1'b0};
    vecs[1]  = '{16'sd2499,   2047, 1'b0};
    vecs[2]  = '{16'sd2500,   2047, 1'b1};
    vecs[3]  = '{-16'sd2500,  -2048, 1'b0};
    vecs[4]  = '{-16'sd2501,  -2048, 1'b1};
    vecs[5]  = '{16'sd0,      0,    1'b0};
    vecs[6]  = '{-16'sd1,     -1,   1'b0};
    vecs[7]  = '{16'sd1,      0,    1'b0};
    vecs[8]  = '{-16'sd2499,  -2048, 1'b0};
    vecs[9]  = '{-16'sd1250,  -1024, 1'b0};
    vecs[10] = '{16'sd625,    512,  1'b0};
    vecs[11] = '{16'sd32767,  2047, 1'b1};
    vecs[12] = '{-16'sd32768, -2048, 1'b1};
    vecs[13] = '{16'sd1200,   983,  1'b0};

    rst_n = 1'b0; start = 1'b0; ch_enable = 4'b0000; out_ready = 1'b1;
    analog_in_mv = {(NUM_CH*IN_W){1'b0}};
`ifdef ADC_OFFSET_CAL_EN
    cal_wr = 1'b0; cal_ch = 2'd0; cal_offset = 12'd0;
`endif
    step(3);
    check("reset_outputs", {busy, out_valid, out_data, out_ch, out_sat, frame_done}, 0);
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 14; i++) begin
      analog_in_mv = {(NUM_CH*IN_W){1'b0}};
      set_in(0, int'(vecs[i].vin));
      kick(4'b0001);
      wait_valid($sformatf("vec%0d", i), 40, e);
      check($sformatf("vec%0d_latency", i), e, 16);
      check($sformatf("vec%0d_data", i), $signed(out_data), vecs[i].exp_code);
      check($sformatf("vec%0d_sat", i), out_sat, vecs[i].exp_sat);
      check($sformatf("vec%0d_ch", i), out_ch, 0);
      check($sformatf("vec%0d_frame_done", i), frame_done, 1);
      check($sformatf("vec%0d_busy_low", i), busy, 0);
      step(1);
      check($sformatf("vec%0d_valid_cleared", i), out_valid, 0);
      check($sformatf("vec%0d_frame_done_pulse", i), frame_done, 0);
    end

    // Two sparse channels, no backpressure.
    analog_in_mv = {(NUM_CH*IN_W){1'b0}};
    set_in(1, -1250);
    set_in(3, 625);
    kick(4'b1010);
    wait_valid("two_ch_first", 40, e);
    check("two_ch_first_latency", e, 16);
    check("two_ch_first_ch", out_ch, 1);
    check("two_ch_first_data", $signed(out_data), -1024);
    check("two_ch_first_no_done", frame_done, 0);
    check("two_ch_first_busy", busy, 1);
    wait_valid("two_ch_second", 40, e);
    check("two_ch_period", e, 15);
    check("two_ch_second_ch", out_ch, 3);
    check("two_ch_second_data", $signed(out_data), 512);
    check("two_ch_second_done", frame_done, 1);
    check("two_ch_busy_falls", busy, 0);
    step(1);
    check("two_ch_after_busy", busy, 0);
    check("two_ch_after_done", frame_done, 0);

    // Four channels with 20 cycles of backpressure on the first result.
    set_in(0, 100); set_in(1, -200); set_in(2, 2600); set_in(3, -3000);
    out_ready = 1'b0;
    kick(4'b1111);
    wait_valid("bp_first", 40, e);
    check("bp_first_latency", e, 16);
    held_ok = 1'b1;
    fds = 0;
    repeat (20) begin
      step(1);
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || $signed(out_data) !== 12'sd81 || busy !== 1'b1)
        held_ok = 1'b0;
      if (frame_done === 1'b1) fds++;
    end
    check("bp_held_stable", held_ok, 1);
    check("bp_no_done_while_stalled", fds, 0);
    out_ready = 1'b1;
    nres = 0;
    for (int c = 0; c < 70; c++) begin
      if (out_valid === 1'b1) begin
        if (nres < 8) begin
          got_ch[nres] = int'(out_ch);
          got_code[nres] = int'($signed(out_data));
          got_sat[nres] = int'(out_sat);
        end
        nres++;
      end
      if (frame_done === 1'b1) fds++;
      step(1);
    end
    check("bp_result_count", nres, 4);
    check("bp_frame_done_count", fds, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_res%0d_ch", k), got_ch[k], exp_ch[k]);
      check($sformatf("bp_res%0d_data", k), got_code[k], exp_code[k]);
      check($sformatf("bp_res%0d_sat", k), got_sat[k], exp_sat[k]);
    end
    check("bp_idle_after", busy, 0);

    // start with no channels enabled is ignored.
    start = 1'b1;
    ch_enable = 4'b0000;
    step(1);
    start = 1'b0;
    bad = 0;
    repeat (5) begin
      if (busy !== 1'b0 || out_valid !== 1'b0 || frame_done !== 1'b0) bad++;
      step(1);
    end
    check("start_empty_mask_ignored", bad, 0);

    // start while busy is ignored.
    analog_in_mv = {(NUM_CH*IN_W){1'b0}};
    set_in(0, 1000);
    set_in(1, 500);
    kick(4'b0001);
    step(4);
    start = 1'b1;
    ch_enable = 4'b1111;
    step(1);
    start = 1'b0;
    ch_enable = 4'b0000;
    wait_valid("busy_start", 40, e);
    check("busy_start_latency", e, 11);
    check("busy_start_ch", out_ch, 0);
    check("busy_start_data", $signed(out_data), 819);
    check("busy_start_done", frame_done, 1);
    bad = 0;
    repeat (40) begin
      step(1);
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("busy_start_no_extra", bad, 0);

    // Reset while the second channel is converting, with a result still held.
    out_ready = 1'b0;
    kick(4'b0011);
    wait_valid("rst_first", 40, e);
    step(8);
    check("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {busy, out_valid, out_data, out_ch, out_sat, frame_done}, 0);
    step(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    repeat (30) begin
      step(1);
      if (out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("rst_no_spurious", bad, 0);

`ifdef ADC_OFFSET_CAL_EN
    cal_wr = 1'b1;
    cal_ch = 2'd0;
    cal_offset = 12'd10;
    step(1);
    cal_wr = 1'b0;
    analog_in_mv = {(NUM_CH*IN_W){1'b0}};
    kick(4'b0001);
    wait_valid("cal_zero", 40, e);
    check("cal_zero_data", $signed(out_data), -10);
    check("cal_zero_sat", out_sat, 0);
    step(1);
    set_in(0, -2500);
    kick(4'b0001);
    wait_valid("cal_clamp", 40, e);
    check("cal_clamp_data", $signed(out_data), -2048);
    check("cal_clamp_sat", out_sat, 1);
    step(1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sar_multi.md
# adc_sar_multi

Parametrised multi-channel SAR ADC model for the crossbar readout path. It samples the signed mV column voltages of up to NUM_CH channels and resolves each with a genuine bit-serial successive-approximation search. Results stream out one channel at a time over a valid/ready handshake with saturation flags. It sits between the crossbar column drivers and the digital accumulator, and replaces the single-channel fixed-latency converter.

## Interface
- NUM_CH, 4: channel count (≥1); CH_W = max(1, $clog2(NUM_CH))
- ADC_BITS, 12: output code width (4..16)
- IN_W, 16: width of each signed mV input
- V_REF_MV, 2500: full scale ±V_REF_MV
- SAMPLE_CYCLES, 2: sample/hold duration in cycles (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- analog_in_mv  in  NUM_CH*IN_W  packed signed inputs; channel i at [i*IN_W +: IN_W]
- ch_enable  in  NUM_CH  channels to convert in the next frame
- start  in  1  frame request, sampled only in IDLE
- busy  out  1  frame in progress
- out_data  out  ADC_BITS  signed result code
- out_ch  out  CH_W  channel index of out_data
- out_sat  out  1  input was outside the convertible range
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- frame_done  out  1  one-cycle pulse: last result of the frame loaded

## Operation
- Reset values: busy=0, out_valid=0, out_data=0, out_ch=0, out_sat=0, frame_done=0, FSM=IDLE, mask=0.
- States: IDLE, SAMPLE, CONVERT, RESULT.
- IDLE:
  - start=1 with ch_enable≠0: latch mask=ch_enable, select the lowest set bit, go to SAMPLE.
  - start with ch_enable=0: ignored; no frame_done.
- SAMPLE: stay SAMPLE_CYCLES cycles. On the exit edge, capture the channel's input into v. Clear the SAR register. Go to CONVERT.
- CONVERT: runs ADC_BITS cycles, MSB first, on offset-binary u. Each cycle:
  - set the trial bit;
  - keep it iff (u_trial − 2^(ADC_BITS−1))·V_REF_MV ≤ v·2^(ADC_BITS−1).
- Compare arithmetic: signed, IN_W+ADC_BITS+2 bits, no truncation.
- Result: code = u − 2^(ADC_BITS−1), which equals floor(v·2^(ADC_BITS−1)/V_REF_MV) clamped to [−2^(ADC_BITS−1), 2^(ADC_BITS−1)−1].
- Saturation: sat = (v ≥ V_REF_MV) || (v < −V_REF_MV).
- RESULT, output register free (!out_valid || out_ready):
  - load out_data, out_ch, out_sat; set out_valid; clear the channel's mask bit;
  - mask bits remain: go to SAMPLE on the next lowest set bit;
  - otherwise: pulse frame_done, go to IDLE.
- RESULT, output register occupied: stall in RESULT. Results are never dropped or overwritten.
- out_valid clears on out_valid && out_ready unless a new result loads on the same edge. Simultaneous accept and load loads the new result.
- Inputs are read only at the capture edge. ch_enable is read only at start.
- start while busy is ignored.
- busy=1 in every state except IDLE.
- Reset mid-frame aborts immediately to reset values; no partial result is emitted.

## Timing
- The start-accept edge is edge 0.
- First-channel path: SAMPLE occupies edges 1..SAMPLE_CYCLES; CONVERT takes ADC_BITS edges; RESULT loads on the next edge.
- First out_valid: high after edge 1+SAMPLE_CYCLES+ADC_BITS+1 (16 by default).
- Per-channel period without backpressure: SAMPLE_CYCLES+ADC_BITS+1 (15 by default).
- Each backpressure cycle in RESULT adds one cycle.
- frame_done is asserted in the same cycle out_valid first shows the last channel's result.
- busy falls on that edge as well.
- Earliest next start: the following cycle.

## Configuration
- ADC_OFFSET_CAL_EN defined:
  - adds ports cal_wr (in, 1), cal_ch (in, CH_W), cal_offset (in, ADC_BITS, signed);
  - per-channel offset registers, reset 0, written when cal_wr=1 in any state;
  - in RESULT, code_out = clamp(code − offset[ch]) to the signed ADC_BITS range;
  - out_sat = sat || clamp_active;
  - a write to the channel currently being converted applies from its RESULT edge.
- Undefined: no cal ports or registers; code_out = code.

## Test plan
- Single channel, defaults, ch_enable=4'b0001, in0=+1000, out_ready=1 → out_data=819, out_ch=0, out_sat=0, out_valid at edge 16, frame_done with it.
- Boundaries → expected out_data/out_sat:
  - +2499 → 2047/0
  - +2500 → 2047/1
  - −2500 → −2048/0
  - −2501 → −2048/1
  - 0 → 0/0
  - −1 → −1/0
- Enables 4'b1010, in1=−1250, in3=+625 → (ch1, −1024) then (ch3, +512), 15 cycles apart; single frame_done; busy low the next cycle.
- Hold out_ready=0 for 20 cycles, 4-channel frame → exactly one result held stable while the FSM stalls in RESULT; after release, all 4 results arrive in channel order, none lost.
- start with ch_enable=0, and start while busy → no state change, no frame_done; rst_n low during CONVERT → all outputs 0 next cycle, no spurious out_valid.
- With ADC_OFFSET_CAL_EN, offset[0]=+10, in0=0 → out_data=−10; offset[0]=+10, in0=−2500 → −2048 with out_sat=1.
